// File: rtl/ball_pkg.sv
// ============================================================================
// Module      : ball_pkg
// Description : Shared constants for the ball renderer pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ball_pkg;

    localparam int c_latency = 3;
    localparam int c_color_w = 3;

    localparam int c_out_v = 3;
    localparam int c_out_r = 2;
    localparam int c_out_g = 1;
    localparam int c_out_b = 0;

    // Index width that stays legal for a single-channel build.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ball_hit_test.sv
// ============================================================================
// Module      : ball_hit_test
// Description : Two-stage distance test of one pixel against one ball.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ball_hit_test
    import ball_pkg::*;
#(
    parameter int HW = 12,
    parameter int VW = 11,
    parameter int CW = 10,
    parameter int RW = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [HW-1:0] hcounter,
    input  logic [VW-1:0] vcounter,
    input  logic [CW-1:0] x,
    input  logic [CW-1:0] y,
    input  logic [RW-1:0] radius,
    input  logic          act,
    output logic          hit
);

    localparam int c_dw = ((HW > VW) ? HW : VW) + 1;
    localparam int c_sw = 2 * c_dw + 1;

    logic [c_dw-1:0] w_h, w_v, w_x, w_y;
    logic signed [c_dw-1:0] r_dx, r_dy;
    logic [RW-1:0] r_rad;
    logic          r_act;

    // Zero-extend before subtracting so edge coordinates never wrap.
    assign w_h = c_dw'(hcounter);
    assign w_v = c_dw'(vcounter);
    assign w_x = c_dw'(x);
    assign w_y = c_dw'(y);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dx  <= '0;
            r_dy  <= '0;
            r_rad <= '0;
            r_act <= 1'b0;
        end else begin
            r_dx  <= $signed(w_h - w_x);
            r_dy  <= $signed(w_v - w_y);
            r_rad <= radius;
            r_act <= act;
        end
    end

    logic signed [2*c_dw-1:0] w_dxe, w_dye, w_dx2, w_dy2;
    logic [c_sw-1:0] w_sum, w_r2;

    assign w_dxe = (2*c_dw)'(r_dx);
    assign w_dye = (2*c_dw)'(r_dy);
    assign w_dx2 = w_dxe * w_dxe;
    assign w_dy2 = w_dye * w_dye;
    assign w_sum = c_sw'($unsigned(w_dx2)) + c_sw'($unsigned(w_dy2));
    assign w_r2  = c_sw'(r_rad) * c_sw'(r_rad);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit <= 1'b0;
        end else begin
            hit <= r_act && (w_sum <= w_r2);
        end
    end

endmodule

`default_nettype wire

// File: rtl/ball_renderer.sv
// ============================================================================
// Module      : ball_renderer
// Description : Per-pixel ball overlay with frame-synchronous shadow registers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ball_renderer
    import ball_pkg::*;
#(
    parameter int CNT = 3,
    parameter int HW  = 12,
    parameter int VW  = 11,
    parameter int CW  = 10,
    parameter int RW  = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     frame_start,
    input  logic                     pix_valid,
    input  logic [HW-1:0]            hcounter,
    input  logic [VW-1:0]            vcounter,
    input  logic [CNT*CW-1:0]        xs,
    input  logic [CNT*CW-1:0]        ys,
    input  logic [CNT*RW-1:0]        radii,
    input  logic [CNT*c_color_w-1:0] colors,
    input  logic [CNT-1:0]           active,
    output logic                     out_valid,
    output logic [3:0]               out,
    output logic [idx_w(CNT)-1:0]    hit_idx
);

    localparam int c_iw = idx_w(CNT);

    logic [CNT*CW-1:0]        r_xs, r_ys;
    logic [CNT*RW-1:0]        r_radii;
    logic [CNT*c_color_w-1:0] r_colors;
    logic [CNT-1:0]           r_active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_xs     <= '0;
            r_ys     <= '0;
            r_radii  <= '0;
            r_colors <= '0;
            r_active <= '0;
        end else if (frame_start) begin
            r_xs     <= xs;
            r_ys     <= ys;
            r_radii  <= radii;
            r_colors <= colors;
            r_active <= active;
        end
    end

    logic [CNT-1:0] w_hit;

    generate
        for (genvar gi = 0; gi < CNT; gi++) begin : g_ch
            ball_hit_test #(
                .HW (HW),
                .VW (VW),
                .CW (CW),
                .RW (RW)
            ) u_hit (
                .clk      (clk),
                .rst_n    (rst_n),
                .hcounter (hcounter),
                .vcounter (vcounter),
                .x        (r_xs[gi*CW +: CW]),
                .y        (r_ys[gi*CW +: CW]),
                .radius   (r_radii[gi*RW +: RW]),
                .act      (r_active[gi]),
                .hit      (w_hit[gi])
            );
        end
    endgenerate

    // Colors ride alongside the pixel so a mid-stream reload cannot recolor it.
    logic                     r_pv1, r_pv2;
    logic [CNT*c_color_w-1:0] r_col1, r_col2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pv1  <= 1'b0;
            r_pv2  <= 1'b0;
            r_col1 <= '0;
            r_col2 <= '0;
        end else begin
            r_pv1  <= pix_valid;
            r_pv2  <= r_pv1;
            r_col1 <= r_colors;
            r_col2 <= r_col1;
        end
    end

    logic [c_iw-1:0]      w_idx;
    logic [c_color_w-1:0] w_rgb;
    logic [3:0]           w_out;

    always_comb begin
        w_idx = '0;
        w_rgb = '0;
        w_out = '0;
        for (int i = CNT - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_idx = c_iw'(i);
                w_rgb = r_col2[i*c_color_w +: c_color_w];
            end
        end
        if (r_pv2 && (|w_hit)) begin
            w_out[c_out_v] = 1'b1;
            w_out[c_out_r] = w_rgb[2];
            w_out[c_out_g] = w_rgb[1];
            w_out[c_out_b] = w_rgb[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            hit_idx   <= '0;
            out_valid <= 1'b0;
        end else begin
            out       <= w_out;
            hit_idx   <= (r_pv2 && (|w_hit)) ? w_idx : '0;
            out_valid <= r_pv2;
        end
    end

endmodule

`default_nettype wire
